// File: rtl/vga_board_renderer.sv
// Pixel pipeline for an N x N sprite board. It looks up the cell, fetches the sprite pixel,
// selects the colour and delays HS/VS, so HC/VC map to vga_color three clocks later.
module vga_board_renderer #(
   parameter int          GRID_N       = 3,
   parameter int          CELL_LOG2    = 7,
   parameter int          SPR_W        = 2,
   parameter int          L_EDGE       = 144,
   parameter int          R_EDGE       = 784,
   parameter int          U_EDGE       = 35,
   parameter int          D_EDGE       = 515,
   parameter int          H_MIN        = 271,
   parameter int          V_MIN        = 82,
   parameter int          BLINK_PERIOD = 50,
   parameter int          BLINK_ON     = 25,
   parameter logic [11:0] GRID_COL     = 12'h000,
   parameter logic [11:0] BG_COL       = 12'hfff,
   parameter logic [11:0] CUR_COL      = 12'hfff,
   parameter logic [11:0] WIN_COL      = 12'hf00,
   localparam int         AW           = $clog2(GRID_N * GRID_N),
   localparam int         CW           = $clog2(GRID_N),
   localparam int         RW           = SPR_W + 2 * CELL_LOG2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [9:0]               HC,
   input  logic [9:0]               VC,
   input  logic                     hs_in,
   input  logic                     vs_in,
   input  logic                     frame_tick,
   input  logic [CW-1:0]            cur_row,
   input  logic [CW-1:0]            cur_col,
   input  logic                     game_over,
   input  logic [GRID_N*GRID_N-1:0] win_mask,
   output logic [AW-1:0]            cell_addr,
   input  logic [SPR_W-1:0]         cell_sprite,
   output logic [RW-1:0]            rom_addr,
   input  logic [11:0]              rom_data,
   output logic [11:0]              vga_color,
   output logic                     hs_out,
   output logic                     vs_out
);

   localparam int BW    = $clog2(BLINK_PERIOD);
   localparam int H_END = H_MIN + (GRID_N << CELL_LOG2);
   localparam int V_END = V_MIN + (GRID_N << CELL_LOG2);
   localparam int MW    = 2 ** AW;
   localparam int NF    = 5;
   localparam int F_ON  = 4;
   localparam int F_RNG = 3;
   localparam int F_GRD = 2;
   localparam int F_CUR = 1;
   localparam int F_WIN = 0;

   logic [9:0]           dx, dy, col, row;
   logic [CELL_LOG2-1:0] hoff, voff;
   logic                 in_range, on_screen, grid, cur_hit, win_bit;
   logic [AW-1:0]        cell_idx;
   logic [MW-1:0]        win_pad;
   logic [NF-1:0]        flags_s0;

   logic [AW-1:0]        cell_addr_d, cell_addr_q;
   logic [CELL_LOG2-1:0] hoff_d, hoff_q, voff_d, voff_q;
   logic [RW-1:0]        rom_addr_d, rom_addr_q;
   logic [11:0]          color_d, color_q;
   logic [BW-1:0]        blink_cnt_d, blink_cnt_q;
   logic                 blink_on;
   logic [NF-1:0]        flag_d [2];
   logic [NF-1:0]        flag_q [2];
   logic [1:0]           sync_d [3];
   logic [1:0]           sync_q [3];

   // Stage 0: cell coordinates, window tests and per-pixel flags
   always_comb begin
      dx        = HC - 10'(H_MIN);
      dy        = VC - 10'(V_MIN);
      col       = dx >> CELL_LOG2;
      row       = dy >> CELL_LOG2;
      hoff      = dx[CELL_LOG2-1:0];
      voff      = dy[CELL_LOG2-1:0];
      in_range  = ({22'd0, HC} >= H_MIN) && ({22'd0, HC} < H_END) &&
                  ({22'd0, VC} >= V_MIN) && ({22'd0, VC} < V_END);
      on_screen = ({22'd0, HC} > L_EDGE) && ({22'd0, HC} <= R_EDGE) &&
                  ({22'd0, VC} > U_EDGE) && ({22'd0, VC} <= D_EDGE);
      grid      = (HC == 10'(H_MIN)) || (VC == 10'(V_MIN)) || (&hoff) || (&voff);
      cell_idx  = AW'(row * GRID_N + col);
      win_pad   = MW'(win_mask);
      cur_hit   = in_range && (row == 10'(cur_row)) && (col == 10'(cur_col));
      win_bit   = in_range && win_pad[cell_idx];
      flags_s0  = {on_screen, in_range, grid, cur_hit, win_bit};
      cell_addr_d = in_range ? cell_idx : '0;
      hoff_d      = hoff;
      voff_d      = voff;
   end

   // Stage 1: the board store answers for cell_addr; form the sprite ROM address
   always_comb begin
      rom_addr_d = {cell_sprite, voff_q, hoff_q};
   end

   always_comb begin
      flag_d[0] = flags_s0;
      flag_d[1] = flag_q[0];
      sync_d[0] = {hs_in, vs_in};
      sync_d[1] = sync_q[0];
      sync_d[2] = sync_q[1];
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pipe
         always_ff @(posedge clk) begin
            if (rst) flag_q[gi] <= '0;
            else     flag_q[gi] <= flag_d[gi];
         end
      end
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync_pipe
         always_ff @(posedge clk) begin
            if (rst) sync_q[gi] <= 2'b11;
            else     sync_q[gi] <= sync_d[gi];
         end
      end
   endgenerate

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      if (frame_tick)
         blink_cnt_d = (blink_cnt_q == BW'(BLINK_PERIOD - 1)) ? '0 : blink_cnt_q + BW'(1);
   end

   assign blink_on = blink_cnt_q < BW'(BLINK_ON);

   // Stage 2: colour priority, rom_data of 0 is transparent
   always_comb begin
      color_d = rom_data;
      if (!flag_q[1][F_ON])
         color_d = 12'h000;
      else if (!flag_q[1][F_RNG])
         color_d = BG_COL;
      else if (flag_q[1][F_GRD])
         color_d = GRID_COL;
      else if (flag_q[1][F_CUR] && blink_on && !game_over)
         color_d = CUR_COL;
      else if (rom_data == 12'h000 && game_over && flag_q[1][F_WIN] && blink_on)
         color_d = WIN_COL;
      else if (rom_data == 12'h000)
         color_d = BG_COL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cell_addr_q <= '0;
         hoff_q      <= '0;
         voff_q      <= '0;
         rom_addr_q  <= '0;
         color_q     <= '0;
         blink_cnt_q <= '0;
      end else begin
         cell_addr_q <= cell_addr_d;
         hoff_q      <= hoff_d;
         voff_q      <= voff_d;
         rom_addr_q  <= rom_addr_d;
         color_q     <= color_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign cell_addr = cell_addr_q;
   assign rom_addr  = rom_addr_q;
   assign vga_color = color_q;
   assign hs_out    = sync_q[2][1];
   assign vs_out    = sync_q[2][0];

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: directed probes with literal colours plus a per-cycle
// comparison against a pixel-rule model fed from a log of every applied input.
module tb_vga_board_renderer;

   localparam int MAXC = 16384;
   localparam logic [15:0] ADDR_0AB = {2'd2, 7'd18, 7'd29};
   localparam logic [15:0] ADDR_C4  = {2'd1, 7'd50, 7'd40};

   logic        clk = 1'b0;
   logic        rst, hs_in, vs_in, frame_tick, game_over;
   logic [9:0]  HC, VC;
   logic [1:0]  cur_row, cur_col;
   logic [8:0]  win_mask;
   logic [3:0]  cell_addr;
   logic [1:0]  cell_sprite;
   logic [15:0] rom_addr;
   logic [11:0] rom_data, vga_color;
   logic        hs_out, vs_out;
   logic [17:0] board;

   int tests = 0;
   int fails = 0;
   int cur   = 0;
   int bcnt  = 0;
   int init_b [9] = '{2, 1, 0, 3, 1, 3, 0, 2, 1};

   int         l_hc [MAXC];
   int         l_vc [MAXC];
   int         l_cr [MAXC];
   int         l_cc [MAXC];
   int         l_bc [MAXC];
   logic [8:0]  l_wm [MAXC];
   logic [17:0] l_bd [MAXC];
   bit         l_go [MAXC];
   bit         l_rst [MAXC];
   bit         l_hs [MAXC];
   bit         l_vs [MAXC];

   always #5 clk = ~clk;

   vga_board_renderer dut (
      .clk         (clk),
      .rst         (rst),
      .HC          (HC),
      .VC          (VC),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .frame_tick  (frame_tick),
      .cur_row     (cur_row),
      .cur_col     (cur_col),
      .game_over   (game_over),
      .win_mask    (win_mask),
      .cell_addr   (cell_addr),
      .cell_sprite (cell_sprite),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .vga_color   (vga_color),
      .hs_out      (hs_out),
      .vs_out      (vs_out)
   );

   function automatic logic [1:0] spr_of(logic [17:0] bd, int a);
      if (a < 0 || a > 8) return 2'b00;
      return bd[a*2 +: 2];
   endfunction

   // Sprite ROM contents: sprite 0 is fully transparent
   function automatic logic [11:0] rom_fn(logic [15:0] a);
      if (a == ADDR_0AB) return 12'h0ab;
      if (a[15:14] == 2'd0) return 12'h000;
      return {a[15:14], 3'b000, a[6:0]};
   endfunction

   assign cell_sprite = spr_of(board, int'(cell_addr));
   assign rom_data    = rom_fn(rom_addr);

   function automatic bit m_on_board(int hc, int vc);
      return hc >= 271 && hc < 271 + 3*128 && vc >= 82 && vc < 82 + 3*128;
   endfunction

   function automatic int m_addr(int hc, int vc);
      if (m_on_board(hc, vc)) return ((vc - 82) / 128) * 3 + (hc - 271) / 128;
      return 0;
   endfunction

   function automatic logic [15:0] m_rom_addr(int hc, int vc, logic [17:0] bd);
      int h = ((hc - 271) & 1023) % 128;
      int v = ((vc - 82) & 1023) % 128;
      return {spr_of(bd, m_addr(hc, vc)), 7'(v), 7'(h)};
   endfunction

   function automatic logic [11:0] m_color(int hc, int vc, int cr, int cc, logic [8:0] wm,
                                           logic [17:0] bd, bit go, int bc);
      int row, col, h, v;
      bit lit;
      logic [11:0] rd;
      if (!(hc > 144 && hc <= 784 && vc > 35 && vc <= 515)) return 12'h000;
      if (!m_on_board(hc, vc)) return 12'hfff;
      col = (hc - 271) / 128;
      row = (vc - 82) / 128;
      h   = (hc - 271) % 128;
      v   = (vc - 82) % 128;
      if (hc == 271 || vc == 82 || h == 127 || v == 127) return 12'h000;
      lit = bc < 25;
      if (row == cr && col == cc && lit && !go) return 12'hfff;
      rd = rom_fn(m_rom_addr(hc, vc, bd));
      if (rd == 12'h000 && go && wm[row*3 + col] && lit) return 12'hf00;
      if (rd == 12'h000) return 12'hfff;
      return rd;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cur);
      end
   endtask

   // Log the inputs of the current cycle, then advance one clock
   task automatic apply();
      if (cur >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cur, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      l_hc[cur] = int'(HC);   l_vc[cur] = int'(VC);
      l_cr[cur] = int'(cur_row); l_cc[cur] = int'(cur_col);
      l_wm[cur] = win_mask;   l_bd[cur] = board;
      l_go[cur] = game_over;  l_rst[cur] = rst;
      l_hs[cur] = hs_in;      l_vs[cur] = vs_in;
      l_bc[cur] = bcnt;
      if (rst) bcnt = 0;
      else if (frame_tick) bcnt = (bcnt + 1) % 50;
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic probe(input int hc, input int vc, input logic [11:0] exp, input string nm);
      HC = 10'(hc);
      VC = 10'(vc);
      repeat (3) apply();
      $display("[TB] probe %s hc=%0d vc=%0d color=%h want=%h", nm, hc, vc, vga_color, exp);
      check(nm, 16'(vga_color), 16'(exp));
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      apply();
      frame_tick = 1'b0;
   endtask

   logic [11:0] e_col;
   logic [15:0] e_rom;
   bit          e_hs, e_vs, rst_any;

   always @(negedge clk) begin
      if (cur >= 3) begin
         rst_any = l_rst[cur-1] || l_rst[cur-2] || l_rst[cur-3];
         if (rst_any) begin
            e_col = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
         end else begin
            e_col = m_color(l_hc[cur-3], l_vc[cur-3], l_cr[cur-3], l_cc[cur-3], l_wm[cur-3],
                            l_bd[cur-2], l_go[cur-1], l_bc[cur-1]);
            e_hs  = l_hs[cur-3];
            e_vs  = l_vs[cur-3];
         end
         check("m_color", 16'(vga_color), 16'(e_col));
         check("m_hs", 16'(hs_out), 16'(e_hs));
         check("m_vs", 16'(vs_out), 16'(e_vs));
         check("m_cell_addr", 16'(cell_addr),
               l_rst[cur-1] ? 16'd0 : 16'(m_addr(l_hc[cur-1], l_vc[cur-1])));
         if (l_rst[cur-1]) begin
            check("m_rom_addr", rom_addr, 16'd0);
         end else if (!l_rst[cur-2]) begin
            e_rom = m_rom_addr(l_hc[cur-2], l_vc[cur-2], l_bd[cur-1]);
            check("m_rom_addr", rom_addr, e_rom);
         end
      end
   end

   initial begin
      rst = 1'b1; HC = '0; VC = '0; hs_in = 1'b1; vs_in = 1'b1; frame_tick = 1'b0;
      cur_row = 2'd3; cur_col = 2'd3; game_over = 1'b0; win_mask = '0;
      for (int k = 0; k < 9; k++) board[k*2 +: 2] = 2'(init_b[k]);
      repeat (3) apply();
      check("rst_color", 16'(vga_color), 16'h000);
      check("rst_hs", 16'(hs_out), 16'd1);
      check("rst_rom_addr", rom_addr, 16'd0);
      rst = 1'b0;

      probe(271, 100, 12'h000, "t1_left_grid");
      probe(271 + 127, 150, 12'h000, "t1_right_grid");

      HC = 10'd300; VC = 10'd100;
      apply();
      check("t2_cell_addr", 16'(cell_addr), 16'd0);
      apply();
      check("t2_rom_addr", rom_addr, ADDR_0AB);
      apply();
      check("t2_color", 16'(vga_color), 16'h0ab);
      HC = 10'd439; VC = 10'd260;
      apply();
      check("t2_cell4_addr", 16'(cell_addr), 16'd4);
      apply();
      check("t2_cell4_rom", rom_addr, ADDR_C4);
      apply();
      check("t2_cell4_color", 16'(vga_color), 16'h428);

      probe(200, 300, 12'hfff, "t3_off_board");
      probe(100, 300, 12'h000, "t3_off_screen");
      probe(271 + 384, 300, 12'hfff, "t3_h_range_end");
      probe(271 + 383, 300, 12'h000, "t3_last_col_grid");
      probe(400, 82 + 384, 12'hfff, "t3_v_range_end");

      cur_row = 2'd1; cur_col = 2'd2;
      for (int f = 0; f <= 50; f++) begin
         probe(271 + 2*128 + 10, 82 + 128 + 10, (f < 25 || f == 50) ? 12'hfff : 12'hc0a,
               "t4_blink");
         tick();
      end

      board = '0; game_over = 1'b1; win_mask = 9'b100_010_001; cur_row = 2'd1; cur_col = 2'd1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            probe(271 + c*128 + 64, 82 + r*128 + 64, (r == c) ? 12'hf00 : 12'hfff, "t5_win_lit");
      repeat (24) tick();
      probe(271 + 128 + 64, 82 + 128 + 64, 12'hfff, "t5_win_dark");
      probe(271 + 64, 82 + 64, 12'hfff, "t5_win_dark0");
      repeat (25) tick();
      probe(271 + 2*128 + 64, 82 + 2*128 + 64, 12'hf00, "t5_win_relit");

      game_over = 1'b0; win_mask = '0; cur_row = 2'd3; cur_col = 2'd3;
      for (int k = 0; k < 9; k++) board[k*2 +: 2] = 2'(init_b[k]);
      HC = 10'd300; VC = 10'd100;
      repeat (3) apply();
      hs_in = 1'b0;
      apply();
      hs_in = 1'b1;
      repeat (2) apply();
      check("t6_hs_low", 16'(hs_out), 16'd0);
      apply();
      check("t6_hs_high", 16'(hs_out), 16'd1);
      vs_in = 1'b0;
      apply();
      vs_in = 1'b1;
      repeat (2) apply();
      check("t6_vs_low", 16'(vs_out), 16'd0);

      hs_in = 1'b0;
      repeat (3) apply();
      check("t6_pre_rst_hs", 16'(hs_out), 16'd0);
      rst = 1'b1;
      apply();
      rst = 1'b0;
      check("t6_rst_color", 16'(vga_color), 16'h000);
      check("t6_rst_hs", 16'(hs_out), 16'd1);
      repeat (2) apply();
      check("t6_refill_color", 16'(vga_color), 16'h000);
      apply();
      check("t6_valid_color", 16'(vga_color), 16'h0ab);
      check("t6_valid_hs", 16'(hs_out), 16'd0);
      hs_in = 1'b1;

      // Scan lines with mid-line cursor/win changes, frame ticks and one reset
      begin
         int vlist [10] = '{30, 36, 82, 100, 209, 210, 300, 465, 466, 515};
         for (int li = 0; li < 10; li++) begin
            game_over = li[0];
            for (int k = 0; k < 9; k++) board[k*2 +: 2] = 2'($urandom_range(0, 3));
            for (int hc = 130; hc < 800; hc += 3) begin
               HC = 10'(hc);
               VC = 10'(vlist[li]);
               if (hc % 35 == 0) begin
                  cur_row  = 2'($urandom_range(0, 3));
                  cur_col  = 2'($urandom_range(0, 3));
                  win_mask = 9'($urandom);
               end
               frame_tick = (hc % 95 == 0);
               hs_in      = !(hc >= 700 && hc < 760);
               vs_in      = (li != 4);
               rst        = (li == 6 && hc == 400);
               apply();
            end
            frame_tick = 1'b0;
            rst = 1'b0;
         end
      end
      repeat (4) apply();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
